// File: rtl/instruction_fetch_unit_pkg.sv
// Shared types and constants for the instruction fetch unit and its IF/ID interface.
package instruction_fetch_unit_pkg;

   localparam logic [31:0] NOP_INSTRUCTION = 32'h0000_0013;

   typedef logic [31:0] instruction_type;

   typedef struct packed {
      logic [31:0]     pc;
      instruction_type instruction;
   } if_id_type;

   typedef struct packed {
      logic [31:0]     pc;
      instruction_type instruction;
   } fetch_entry_type;

   function automatic logic [31:0] align_word(input logic [31:0] addr);
      return addr & 32'hFFFF_FFFC;
   endfunction

endpackage

// File: rtl/instruction_fetch_unit_if.sv
// Fetch-side bus: instruction memory handshake, EX redirect, decode stall and IF/ID output.
// master = fetch unit, slave = memory/pipeline environment.
interface instruction_fetch_unit_if;
   import instruction_fetch_unit_pkg::*;

   logic        imem_req_valid;
   logic        imem_req_ready;
   logic [31:0] imem_req_addr;
   logic        imem_rsp_valid;
   logic [31:0] imem_rsp_data;
   logic        branch_taken;
   logic [31:0] branch_target;
   logic        stall;
   logic        if_id_valid;
   if_id_type   if_id;

   modport master (
      output imem_req_valid, imem_req_addr, if_id_valid, if_id,
      input  imem_req_ready, imem_rsp_valid, imem_rsp_data, branch_taken, branch_target, stall
   );

   modport slave (
      input  imem_req_valid, imem_req_addr, if_id_valid, if_id,
      output imem_req_ready, imem_rsp_valid, imem_rsp_data, branch_taken, branch_target, stall
   );

endinterface

// File: rtl/instruction_fetch_unit_fetch_fifo.sv
// Fetch buffer: power-of-two circular FIFO with synchronous flush (flush beats push).
module instruction_fetch_unit_fetch_fifo
   import instruction_fetch_unit_pkg::*;
#(
   parameter int unsigned DEPTH = 2,
   localparam int unsigned CntW = $clog2(DEPTH + 1),
   localparam int unsigned PtrW = $clog2(DEPTH)
) (
   input  logic            clk_i,
   input  logic            reset_ni,
   input  logic            push_i,
   input  logic            pop_i,
   input  logic            flush_i,
   input  fetch_entry_type data_i,
   output logic [CntW-1:0] count_o,
   output fetch_entry_type head_o,
   output logic            full_o,
   output logic            empty_o
);

   localparam logic [CntW-1:0] DepthC = CntW'(DEPTH);

   fetch_entry_type mem_q [DEPTH];
   logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
   logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
   logic [CntW-1:0] count_q, count_d;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (flush_i) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (push_i) wr_ptr_d = wr_ptr_q + PtrW'(1);
         if (pop_i)  rd_ptr_d = rd_ptr_q + PtrW'(1);
         count_d = count_q + CntW'(push_i) - CntW'(pop_i);
      end
   end

   always_ff @(posedge clk_i) begin
      if (!reset_ni) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   always_ff @(posedge clk_i) begin
      if (push_i && !flush_i) mem_q[wr_ptr_q] <= data_i;
   end

   assign count_o = count_q;
   assign head_o  = mem_q[rd_ptr_q];
   assign full_o  = (count_q == DepthC);
   assign empty_o = (count_q == '0);

endmodule

// File: rtl/instruction_fetch_unit.sv
// IF stage: PC generation, credit-limited in-order imem requests, response buffering and
// redirect squash. Define FETCH_PERF_CNT_EN to add the perf_fetched/perf_squashed counters.
module instruction_fetch_unit
   import instruction_fetch_unit_pkg::*;
#(
   parameter logic [31:0] RESET_PC   = 32'h0000_0000,
   parameter int unsigned FIFO_DEPTH = 2
) (
   input  logic                      clk,
   input  logic                      reset_n,
   instruction_fetch_unit_if.master  bus
`ifdef FETCH_PERF_CNT_EN
   ,
   output logic [31:0]               perf_fetched,
   output logic [31:0]               perf_squashed
`endif
);

   localparam int unsigned CntW = $clog2(FIFO_DEPTH + 1);
   localparam logic [CntW:0] DepthW = FIFO_DEPTH[CntW:0];

   logic [31:0]     fetch_pc_q, fetch_pc_d;
   logic [31:0]     rsp_pc_q, rsp_pc_d;
   logic [CntW-1:0] outstanding_q, outstanding_d;
   logic [CntW-1:0] discard_q, discard_d;

   logic [CntW-1:0] fifo_count;
   fetch_entry_type fifo_head;
   fetch_entry_type push_entry;
   logic            fifo_full, fifo_empty;
   logic [CntW:0]   occupancy;
   logic [31:0]     target_aligned;
   logic            credit, accept, rsp_drop, push, pop;

   assign target_aligned = align_word(bus.branch_target);
   // Squashed fetches keep holding credit until their response drains.
   assign occupancy = {1'b0, fifo_count} + {1'b0, outstanding_q};
   assign credit    = ~fifo_full & (occupancy < DepthW);

   assign bus.imem_req_valid = reset_n & credit & ~bus.branch_taken;
   assign bus.imem_req_addr  = fetch_pc_q;
   assign bus.if_id_valid    = ~fifo_empty;

   always_comb begin
      bus.if_id = if_id_type'{pc: 32'h0, instruction: NOP_INSTRUCTION};
      if (!fifo_empty) bus.if_id = if_id_type'(fifo_head);
   end

   always_comb begin
      accept     = bus.imem_req_valid & bus.imem_req_ready;
      rsp_drop   = bus.imem_rsp_valid & (bus.branch_taken | (discard_q != '0));
      push       = bus.imem_rsp_valid & ~rsp_drop;
      pop        = ~fifo_empty & ~bus.stall & ~bus.branch_taken;
      push_entry = fetch_entry_type'{pc: rsp_pc_q, instruction: bus.imem_rsp_data};

      fetch_pc_d    = fetch_pc_q;
      rsp_pc_d      = rsp_pc_q;
      outstanding_d = outstanding_q;
      discard_d     = discard_q;

      if (bus.branch_taken) begin
         fetch_pc_d    = target_aligned;
         rsp_pc_d      = target_aligned;
         outstanding_d = outstanding_q - CntW'(bus.imem_rsp_valid);
         discard_d     = outstanding_q - CntW'(bus.imem_rsp_valid);
      end else begin
         if (accept)   fetch_pc_d = fetch_pc_q + 32'd4;
         if (push)     rsp_pc_d   = rsp_pc_q + 32'd4;
         if (rsp_drop) discard_d  = discard_q - CntW'(1);
         outstanding_d = outstanding_q + CntW'(accept) - CntW'(bus.imem_rsp_valid);
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         fetch_pc_q    <= RESET_PC;
         rsp_pc_q      <= RESET_PC;
         outstanding_q <= '0;
         discard_q     <= '0;
      end else begin
         fetch_pc_q    <= fetch_pc_d;
         rsp_pc_q      <= rsp_pc_d;
         outstanding_q <= outstanding_d;
         discard_q     <= discard_d;
      end
   end

   instruction_fetch_unit_fetch_fifo #(
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk_i    (clk),
      .reset_ni (reset_n),
      .push_i   (push),
      .pop_i    (pop),
      .flush_i  (bus.branch_taken),
      .data_i   (push_entry),
      .count_o  (fifo_count),
      .head_o   (fifo_head),
      .full_o   (fifo_full),
      .empty_o  (fifo_empty)
   );

`ifdef FETCH_PERF_CNT_EN
   logic [31:0] perf_fetched_q, perf_squashed_q;
   logic [31:0] squash_inc;

   always_comb begin
      squash_inc = 32'(rsp_drop);
      if (bus.branch_taken) squash_inc = squash_inc + 32'(fifo_count);
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         perf_fetched_q  <= '0;
         perf_squashed_q <= '0;
      end else begin
         perf_fetched_q  <= perf_fetched_q + 32'(pop);
         perf_squashed_q <= perf_squashed_q + squash_inc;
      end
   end

   assign perf_fetched  = perf_fetched_q;
   assign perf_squashed = perf_squashed_q;
`endif

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Bench for instruction_fetch_unit: directed scenarios then random traffic, all checked each
// cycle against a queue-based model of the fetch stream. Honours FETCH_PERF_CNT_EN.
module tb_instruction_fetch_unit;
   import instruction_fetch_unit_pkg::*;

   localparam logic [31:0] ResetPc = 32'h0000_0000;
   localparam int unsigned Depth   = 2;

   logic clk = 1'b0;
   logic reset_n;

   instruction_fetch_unit_if bus ();

`ifdef FETCH_PERF_CNT_EN
   logic [31:0] perf_fetched, perf_squashed;
`endif

   instruction_fetch_unit #(
      .RESET_PC   (ResetPc),
      .FIFO_DEPTH (Depth)
   ) dut (
      .clk           (clk),
      .reset_n       (reset_n),
      .bus           (bus)
`ifdef FETCH_PERF_CNT_EN
      ,
      .perf_fetched  (perf_fetched),
      .perf_squashed (perf_squashed)
`endif
   );

   always #5 clk = ~clk;

   int vectors;
   int miscompares;

   // Model: mq = addresses accepted by memory awaiting response, dq = PCs buffered for decode.
   logic [31:0] mq[$];
   logic [31:0] dq[$];
   int          stale;
   logic [31:0] next_fetch;
   logic [31:0] m_fetched, m_squashed;

   logic        rst_v, ready_v, stall_v, branch_v;
   logic [31:0] target_v;
   int          rsp_pct;
   int          accepts_seen;
   logic [31:0] obs[$];
   int          idx;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return a ^ 32'hC0DE_0000;
   endfunction

   task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
      vectors++;
      assert (observed === expected) else begin
         miscompares++;
         $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
      end
   endtask

   task automatic check_obs(input string tag, input int i, input logic [31:0] expected);
      if (i < obs.size()) check(tag, 64'(obs[i]), 64'(expected));
      else check({tag, "_missing"}, 64'(obs.size()), 64'(i + 1));
   endtask

   task automatic settle();
      @(posedge clk);
      #2;
   endtask

   task automatic step();
      logic        rsp, exp_req, popd;
      logic [31:0] a;
      @(negedge clk);
      rsp = rst_v && (mq.size() > 0) && (int'($urandom_range(0, 99)) < rsp_pct);
      reset_n            = rst_v;
      bus.imem_req_ready = ready_v;
      bus.stall          = stall_v;
      bus.branch_taken   = branch_v;
      bus.branch_target  = target_v;
      bus.imem_rsp_valid = rsp;
      bus.imem_rsp_data  = rsp ? mem_word(mq[0]) : $urandom();
      #1;
      exp_req = rst_v && ((dq.size() + mq.size()) < int'(Depth)) && !branch_v;
      check("req_valid", 64'(bus.imem_req_valid), 64'(exp_req));
      if (rst_v) begin
         check("if_id_valid", 64'(bus.if_id_valid), 64'(dq.size() != 0));
         if (dq.size() != 0) check("if_id", 64'(bus.if_id), {dq[0], mem_word(dq[0])});
         else check("if_id_idle", 64'(bus.if_id), {32'h0, NOP_INSTRUCTION});
         if (exp_req) check("req_addr", 64'(bus.imem_req_addr), 64'(next_fetch));
`ifdef FETCH_PERF_CNT_EN
         check("perf_fetched", 64'(perf_fetched), 64'(m_fetched));
         check("perf_squashed", 64'(perf_squashed), 64'(m_squashed));
`endif
         if (bus.if_id_valid && !stall_v && !branch_v) obs.push_back(bus.if_id.pc);
         if (bus.imem_req_valid && ready_v) accepts_seen++;
      end
      popd = rst_v && (dq.size() != 0) && !stall_v && !branch_v;
      if (!rst_v) begin
         mq.delete();
         dq.delete();
         stale      = 0;
         next_fetch = ResetPc;
         m_fetched  = '0;
         m_squashed = '0;
      end else if (branch_v) begin
         m_squashed = m_squashed + 32'(dq.size()) + 32'(rsp);
         dq.delete();
         if (rsp) void'(mq.pop_front());
         stale      = mq.size();
         next_fetch = target_v & 32'hFFFF_FFFC;
      end else begin
         if (popd) begin
            void'(dq.pop_front());
            m_fetched = m_fetched + 32'd1;
         end
         if (rsp) begin
            a = mq.pop_front();
            if (stale > 0) begin
               stale--;
               m_squashed = m_squashed + 32'd1;
            end else begin
               dq.push_back(a);
            end
         end
         if (exp_req && ready_v) begin
            mq.push_back(next_fetch);
            next_fetch = next_fetch + 32'd4;
         end
      end
   endtask

   initial begin
      vectors = 0; miscompares = 0; stale = 0; accepts_seen = 0;
      next_fetch = ResetPc; m_fetched = '0; m_squashed = '0;
      rst_v = 1'b0; ready_v = 1'b1; stall_v = 1'b0; branch_v = 1'b0; target_v = '0;
      rsp_pct = 100;
      reset_n = 1'b0;
      bus.imem_req_ready = 1'b0; bus.imem_rsp_valid = 1'b0; bus.imem_rsp_data = '0;
      bus.stall = 1'b0; bus.branch_taken = 1'b0; bus.branch_target = '0;

      repeat (2) step();
      settle();
      check("rst_if_id_valid", 64'(bus.if_id_valid), 64'd0);
      check("rst_if_id", 64'(bus.if_id), {32'h0, NOP_INSTRUCTION});

      // Streaming with a 1-cycle memory.
      rst_v = 1'b1;
      repeat (5) step();
      check_obs("stream_pc0", 0, 32'h0);
      check_obs("stream_pc1", 1, 32'h4);

      // Decode stall: buffer fills and no further requests are accepted.
      stall_v = 1'b1;
      step();
      accepts_seen = 0;
      repeat (4) step();
      check("stall_accepts", 64'(accepts_seen), 64'd0);
      settle();
      check("stall_hold_pc", 64'(bus.if_id.pc), 64'h8);
      stall_v = 1'b0;
      repeat (3) step();
      check_obs("release_pc8", 2, 32'h8);
      check_obs("release_pcC", 3, 32'hC);

      // Redirect with two requests outstanding.
      rsp_pct = 0;
      repeat (4) step();
      branch_v = 1'b1; target_v = 32'h103;
      step();
      settle();
      check("redir_valid", 64'(bus.if_id_valid), 64'd0);
      branch_v = 1'b0; rsp_pct = 100;
      idx = obs.size();
      repeat (8) step();
      check_obs("redir_first_pc", idx, 32'h100);

      // Redirect coincident with a response while decode is stalled.
      rsp_pct = 0;
      repeat (4) step();
      stall_v = 1'b1; rsp_pct = 100; branch_v = 1'b1; target_v = 32'h200;
      step();
      settle();
      check("redir_rsp_valid", 64'(bus.if_id_valid), 64'd0);
      branch_v = 1'b0; stall_v = 1'b0;
      idx = obs.size();
      repeat (8) step();
      check_obs("redir_rsp_first_pc", idx, 32'h200);

      // Memory not ready: address holds, then reset mid-wait.
      branch_v = 1'b1; target_v = 32'h10; ready_v = 1'b0;
      step();
      branch_v = 1'b0;
      for (int i = 0; i < 4; i++) begin
         step();
         settle();
         check("wait_addr", 64'(bus.imem_req_addr), 64'h10);
      end
      rst_v = 1'b0;
      step();
      settle();
      check("rst_mid_addr", 64'(bus.imem_req_addr), 64'(ResetPc));
      check("rst_mid_valid", 64'(bus.if_id_valid), 64'd0);
      rst_v = 1'b1; ready_v = 1'b1;
      repeat (3) step();

      // Random traffic.
      for (int i = 0; i < 3000; i++) begin
         rst_v    = ($urandom_range(0, 499) != 0);
         ready_v  = ($urandom_range(0, 3) != 0);
         stall_v  = ($urandom_range(0, 3) == 0);
         branch_v = ($urandom_range(0, 15) == 0);
         target_v = $urandom();
         rsp_pct  = 60;
         step();
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
